// File: rtl/nap_session_ctrl_pkg.sv
// nap_pkg: shared types, constants and helpers for the nap session controller.
// Holds the FSM state encoding, the BCD time layout, the entry validity check
// and the elaboration-time seconds-to-BCD conversion.
package nap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SLEEP  = 3'd2,
    ST_ALARM  = 3'd3,
    ST_PAUSED = 3'd4
  } nap_state_t;

  // Packed so that hh10 lands in the top nibble: matches the HHMMSS bus layout.
  typedef struct packed {
    logic [3:0] hh10;
    logic [3:0] hh1;
    logic [3:0] mm10;
    logic [3:0] mm1;
    logic [3:0] ss10;
    logic [3:0] ss1;
  } bcd_time_t;

  // Default durations, slice 0 in the low bits: 00:20:00, 00:30:00, 01:30:00.
  localparam logic [71:0] DEFAULT_PRESETS = {24'h013000, 24'h003000, 24'h002000};

  // A confirmed entry must be a real, non-zero clock duration up to 23:59:59.
  function automatic logic time_valid(input bcd_time_t t);
    logic hh_ok;
    hh_ok = (t.hh10 < 4'd2) || ((t.hh10 == 4'd2) && (t.hh1 <= 4'd3));
    return hh_ok && (t.hh1 <= 4'd9) && (t.mm10 <= 4'd5) && (t.mm1 <= 4'd9) &&
           (t.ss10 <= 4'd5) && (t.ss1 <= 4'd9) && (t != '0);
  endfunction

  // Used only on parameters, so it folds to a constant at elaboration.
  function automatic logic [23:0] sec_to_bcd(input int unsigned s);
    int unsigned h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

endpackage

// File: rtl/nap_session_ctrl_if.sv
// nap_session_ctrl_if: keypad/pulse inputs and display/driver outputs of the
// nap session controller. master = stimulus side, slave = controller side.
interface nap_session_ctrl_if #(
  parameter int NUM_PRESETS = 3
);
  localparam int IDX_W = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;

  logic             key_valid;
  logic [3:0]       key_digit;
  logic             sharp;
  logic             cancel;
  logic             preset_load;
  logic [IDX_W-1:0] preset_idx;
  logic [23:0]      time_bcd;
  logic [2:0]       state;
  logic             mode_setup;
  logic             mode_sleep;
  logic             mode_alarm;
  logic             alarm_on;
  logic             entry_err;
  logic [3:0]       snooze_cnt;

  modport master (
    output key_valid, key_digit, sharp, cancel, preset_load, preset_idx,
    input  time_bcd, state, mode_setup, mode_sleep, mode_alarm, alarm_on,
           entry_err, snooze_cnt
  );

  modport slave (
    input  key_valid, key_digit, sharp, cancel, preset_load, preset_idx,
    output time_bcd, state, mode_setup, mode_sleep, mode_alarm, alarm_on,
           entry_err, snooze_cnt
  );
endinterface

// File: rtl/nap_session_ctrl_bcd_countdown.sv
// bcd_countdown: six-digit HHMMSS BCD register with parallel load and a
// one-second decrement. Load has priority over decrement. The caller must not
// decrement a zero value (is_zero is provided for that guard).
module bcd_countdown (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [23:0] load_val,
  input  logic        dec,
  output logic [23:0] q,
  output logic        is_zero
);
  logic [23:0] q_reg;
  logic [23:0] dec_val;
  logic [5:0]  borrow;

  assign borrow[0] = 1'b1;

  // Borrow ripples from ss1 upward; tens of minutes/seconds wrap to 5, others to 9.
  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    localparam logic [3:0] MAXD = ((gi == 1) || (gi == 3)) ? 4'd5 : 4'd9;
    logic [3:0] cur;
    assign cur = q_reg[gi*4 +: 4];
    assign dec_val[gi*4 +: 4] = !borrow[gi] ? cur :
                                (cur == 4'd0) ? MAXD : cur - 4'd1;
    if (gi < 5) begin : g_chain
      assign borrow[gi+1] = borrow[gi] && (cur == 4'd0);
    end
  end

  // Time register: load beats decrement.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= load_val;
    end else if (dec) begin
      q_reg <= dec_val;
    end
  end

  assign q       = q_reg;
  assign is_zero = (q_reg == 24'h0);
endmodule

// File: rtl/nap_session_ctrl.sv
// nap_session_ctrl: session FSM (IDLE/SETUP/SLEEP/ALARM), keypad/preset time
// entry, 1 Hz countdown from an internal prescaler, bounded snooze and alarm
// timeout. Define NAP_PAUSE_EN to let sharp pause/resume a running countdown.
module nap_session_ctrl
  import nap_pkg::*;
#(
  parameter int TICK_DIV          = 50000000,
  parameter int NUM_PRESETS       = 3,
  parameter logic [NUM_PRESETS*24-1:0] PRESETS = DEFAULT_PRESETS,
  parameter int SNOOZE_SEC        = 300,
  parameter int MAX_SNOOZE        = 3,
  parameter int ALARM_TIMEOUT_SEC = 60
) (
  input logic              clock,
  input logic              reset,
  nap_session_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;
  localparam int PW    = $clog2(TICK_DIV);
  localparam int TO_W  = (ALARM_TIMEOUT_SEC < 2) ? 1 : $clog2(ALARM_TIMEOUT_SEC + 1);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(ALARM_TIMEOUT_SEC - 1);
  localparam logic [23:0]     SNOOZE_BCD = sec_to_bcd(SNOOZE_SEC);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_SETUP  = ST_SETUP;
  localparam logic [2:0] S_SLEEP  = ST_SLEEP;
  localparam logic [2:0] S_ALARM  = ST_ALARM;
`ifdef NAP_PAUSE_EN
  localparam logic [2:0] S_PAUSED = ST_PAUSED;
`endif

  logic [2:0]      state_reg, state_next;
  logic [PW-1:0]   presc_reg, presc_next;
  logic [3:0]      snooze_reg, snooze_next;
  logic [TO_W-1:0] tcnt_reg, tcnt_next;
  logic            alarm_reg, err_reg, err_next;
  logic            cd_load, cd_dec, cd_zero;
  logic [23:0]     cd_load_val, cd_q, preset_val, shifted;
  logic            tick, digit_ok;

  bcd_countdown u_countdown (
    .clock    (clock),
    .reset    (reset),
    .load     (cd_load),
    .load_val (cd_load_val),
    .dec      (cd_dec),
    .q        (cd_q),
    .is_zero  (cd_zero)
  );

  assign tick     = (presc_reg == PRESC_LAST);
  assign digit_ok = (bus.key_digit <= 4'd9);
  assign shifted  = {cd_q[19:0], bus.key_digit};

  // Preset select; out-of-range indices fall back to slice 0.
  always_comb begin
    preset_val = PRESETS[23:0];
    for (int i = 1; i < NUM_PRESETS; i++) begin
      if (bus.preset_idx == IDX_W'(i)) preset_val = PRESETS[i*24 +: 24];
    end
  end

  // Next-state logic: cancel first, then the per-state rules.
  always_comb begin
    state_next  = state_reg;
    presc_next  = presc_reg;
    snooze_next = snooze_reg;
    tcnt_next   = tcnt_reg;
    err_next    = 1'b0;
    cd_load     = 1'b0;
    cd_load_val = 24'h0;
    cd_dec      = 1'b0;
    if (bus.cancel) begin
      state_next  = S_IDLE;
      presc_next  = '0;
      snooze_next = '0;
      tcnt_next   = '0;
      cd_load     = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // The waking event is also applied as a SETUP edit.
          if (bus.preset_load) begin
            state_next  = S_SETUP;
            cd_load     = 1'b1;
            cd_load_val = preset_val;
          end else if (bus.key_valid) begin
            state_next  = S_SETUP;
            cd_load     = digit_ok;
            cd_load_val = shifted;
          end
        end
        S_SETUP: begin
          if (bus.sharp) begin
            if (time_valid(bcd_time_t'(cd_q))) begin
              state_next  = S_SLEEP;
              presc_next  = '0;
              snooze_next = '0;
            end else begin
              cd_load  = 1'b1;
              err_next = 1'b1;
            end
          end else if (bus.preset_load) begin
            cd_load     = 1'b1;
            cd_load_val = preset_val;
          end else if (bus.key_valid && digit_ok) begin
            cd_load     = 1'b1;
            cd_load_val = shifted;
          end
        end
        S_SLEEP: begin
`ifdef NAP_PAUSE_EN
          if (bus.sharp) state_next = S_PAUSED;
          else
`endif
          if (tick) begin
            presc_next = '0;
            cd_dec     = !cd_zero;
            if (cd_q == 24'h000001) begin
              state_next = S_ALARM;
              tcnt_next  = '0;
            end
          end else begin
            presc_next = presc_reg + 1'b1;
          end
        end
        S_ALARM: begin
          if (bus.sharp) begin
            presc_next = '0;
            if (snooze_reg < 4'(MAX_SNOOZE)) begin
              state_next  = S_SLEEP;
              snooze_next = snooze_reg + 4'd1;
              cd_load     = 1'b1;
              cd_load_val = SNOOZE_BCD;
            end else begin
              state_next = S_IDLE;
            end
          end else if (tick) begin
            presc_next = '0;
            if (tcnt_reg == TO_LAST) begin
              state_next = S_IDLE;
              tcnt_next  = '0;
            end else begin
              tcnt_next = tcnt_reg + 1'b1;
            end
          end else begin
            presc_next = presc_reg + 1'b1;
          end
        end
`ifdef NAP_PAUSE_EN
        S_PAUSED: begin
          if (bus.sharp) state_next = S_SLEEP;
        end
`endif
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State registers; alarm_on is registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      presc_reg  <= '0;
      snooze_reg <= '0;
      tcnt_reg   <= '0;
      alarm_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      presc_reg  <= presc_next;
      snooze_reg <= snooze_next;
      tcnt_reg   <= tcnt_next;
      alarm_reg  <= (state_next == S_ALARM);
      err_reg    <= err_next;
    end
  end

  assign bus.time_bcd   = cd_q;
  assign bus.state      = state_reg;
  assign bus.mode_setup = (state_reg == S_SETUP);
  assign bus.mode_sleep = (state_reg == S_SLEEP);
  assign bus.mode_alarm = (state_reg == S_ALARM);
  assign bus.alarm_on   = alarm_reg;
  assign bus.entry_err  = err_reg;
  assign bus.snooze_cnt = snooze_reg;
endmodule

// File: doc/nap_session_ctrl.md
Name: nap_session_ctrl

Overview:
- Parametrised successor to the fixed-mode nap controller: one block owns session FSM, BCD time entry, countdown, snooze and alarm timeout.
- Accepts preset or keypad-entered HH:MM:SS and counts down at 1 Hz from an internal prescaler.
- Raises an alarm at zero and supports a bounded number of snoozes.
- Sits between keypad/LTP pulse logic and the display/piezo/light drivers; replaces separate time_register, mode FSM and setting muxes.

Parameters:
- TICK_DIV, 50000000: clock cycles per one-second tick (>=2).
- NUM_PRESETS, 3: number of preset durations (1..8).
- PRESETS, {24'h013000,24'h003000,24'h002000}: packed BCD HHMMSS. Index 0 is the LSB slice (00:20:00).
- SNOOZE_SEC, 300: snooze reload in seconds (1..3599). Converted to BCD at elaboration.
- MAX_SNOOZE, 3: snoozes allowed per session (0..15).
- ALARM_TIMEOUT_SEC, 60: alarm auto-stop after this many ticks.

Ports:
- clock in 1: system clock.
- reset in 1: synchronous, active-high.
- key_valid in 1: one-cycle strobe, key_digit valid.
- key_digit in 4: decimal digit 0..9. Values >9 are ignored.
- sharp in 1: one-cycle confirm pulse.
- cancel in 1: one-cycle abort pulse.
- preset_load in 1: one-cycle strobe.
- preset_idx in $clog2(NUM_PRESETS) (min 1): preset select.
- time_bcd out 24: current HHMMSS in BCD.
- state out 3: encoded FSM state.
- mode_setup, mode_sleep, mode_alarm out 1 each: one-hot state decodes.
- alarm_on out 1: drives piezo/light enable.
- entry_err out 1: one-cycle pulse on rejected confirm.
- snooze_cnt out 4: snoozes used this session.

Behaviour:
- States: IDLE=0, SETUP=1, SLEEP=2, ALARM=3, PAUSED=4 (PAUSED exists only with the macro).
- Reset values:
  - state=IDLE; time_bcd=0; snooze_cnt=0.
  - alarm_on=0; entry_err=0; prescaler=0.
- IDLE:
  - key_valid or preset_load -> SETUP, and the same event is applied in SETUP rules on that cycle.
  - sharp ignored.
- SETUP:
  - key_valid with digit<=9: time_bcd <= {time_bcd[19:0], key_digit}.
  - preset_load: time_bcd <= PRESETS slice. Index >= NUM_PRESETS -> slice 0.
  - sharp with valid time (HH<=23, MM tens<=5, SS tens<=5, nonzero) -> SLEEP: prescaler=0, snooze_cnt=0.
  - sharp with invalid time: stay in SETUP, time_bcd=0, entry_err pulses next cycle.
  - key_valid and preset_load in the same cycle: preset wins.
- SLEEP:
  - Prescaler counts 0..TICK_DIV-1; tick when it equals TICK_DIV-1.
  - On tick, time_bcd decrements by one second with BCD borrow (SS 00->59, MM 00->59, HH borrow).
  - Decrement from 000001 gives 000000 and -> ALARM on the same edge: alarm_on=1, timeout counter=0.
  - time_bcd never wraps below 000000.
- ALARM:
  - time_bcd holds 000000; prescaler keeps running; each tick increments the timeout counter.
  - sharp with snooze_cnt < MAX_SNOOZE: time_bcd <= SNOOZE_SEC BCD, snooze_cnt+1, alarm_on=0, prescaler=0 -> SLEEP.
  - sharp with snooze_cnt == MAX_SNOOZE -> IDLE with alarm_on=0.
  - Timeout counter reaching ALARM_TIMEOUT_SEC -> IDLE, alarm_on=0.
  - sharp and timeout on the same cycle: sharp wins.
- cancel in any state -> IDLE next edge: time_bcd=0, alarm_on=0, snooze_cnt=0. cancel beats every other input that cycle.
- alarm_on is registered and equals (state==ALARM).
- All state changes take effect one clock after the qualifying input.

Optional Feature:
- NAP_PAUSE_EN defined:
  - sharp in SLEEP -> PAUSED; prescaler and time_bcd frozen.
  - sharp in PAUSED -> SLEEP, resuming the prescaler from its held value.
  - cancel from PAUSED -> IDLE.
- Undefined: PAUSED is unreachable and sharp in SLEEP is ignored.

Decomposition:
- Package nap_pkg holds:
  - state enum type nap_state_t.
  - BCD time typedef (6x4-bit struct hh10,hh1,mm10,mm1,ss10,ss1).
  - Validity-check function.
  - Seconds-to-BCD constant function.
  - Default preset constants.
- Sub-module bcd_countdown: 6-digit BCD register with load, decrement-enable and is_zero output. It holds the borrow chain and keeps the FSM small.

Test Plan:
- Keys 0,0,0,0,0,3 then sharp, TICK_DIV=4 -> time_bcd 000003→000002→000001→000000 at 4-cycle spacing. ALARM is entered on the cycle time reaches 000000; alarm_on=1.
- Keys 2,4,0,0,0,0 then sharp -> entry_err one-cycle pulse, state stays SETUP, time_bcd=000000.
- preset_idx=2, preset_load, sharp -> time_bcd=013000, then first tick gives 012959.
- MAX_SNOOZE=1, SNOOZE_SEC=5:
  - First sharp in ALARM -> 000005, snooze_cnt=1, SLEEP.
  - Second sharp in ALARM -> IDLE, alarm_on=0.
- ALARM_TIMEOUT_SEC=2, no input -> IDLE two ticks after alarm. cancel asserted mid-SLEEP at 000130 -> IDLE, time_bcd=000000.
- NAP_PAUSE_EN build:
  - sharp at 000010 -> PAUSED.
  - 3*TICK_DIV cycles -> still 000010.
  - sharp -> SLEEP; next tick gives 000009.
